// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and strobe bundle for the fetch sequencer
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_T0     = 3'd1,
      S_T1     = 3'd2,
      S_T2     = 3'd3,
      S_EXEC   = 3'd4,
      S_BRANCH = 3'd5,
      S_HALTED = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   typedef struct packed {
      logic pc_out;
      logic mar_in;
      logic inc_pc;
      logic z_in;
      logic z_lo_out;
      logic pc_in;
      logic mem_read;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic branch_out;
      logic exec_active;
      logic halted;
      logic fault;
   } strobes_t;

endpackage

// File: rtl/pc_sequencer_wait_timer.sv
// wait_timer: 8-bit clearable up-counter flagging when it reaches MEM_TIMEOUT
module wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic clr,
   input  logic start,
   input  logic tick,
   output logic expired
);

   logic [7:0] count;

   // start restarts the count ahead of a new wait; tick advances it one cycle
   always_ff @(posedge clk or posedge clr)
      if (clr) count <= '0;
      else if (start) count <= '0;
      else if (tick) count <= count + 8'd1;

   assign expired = count == 8'(MEM_TIMEOUT);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch and PC-update control-strobe sequencer
module pc_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic        mem_ready,
   input  logic        exec_done,
   input  logic        branch_req,
   input  logic        halt_req,
   output logic        pc_out,
   output logic        mar_in,
   output logic        inc_pc,
   output logic        z_in,
   output logic        z_lo_out,
   output logic        pc_in,
   output logic        mem_read,
   output logic        mdr_in,
   output logic        mdr_out,
   output logic        ir_in,
   output logic        branch_out,
   output logic        exec_active,
   output logic        halted,
   output logic        fault,
   output logic [31:0] instr_count
);

   state_t   state, next;
   strobes_t s;
   logic     expired;

   // T0 always precedes T1, so clearing there gives a fresh count on T1 entry
   wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk(clk),
      .clr(clr),
      .start(state == S_T0),
      .tick(state == S_T1 && !mem_ready),
      .expired(expired)
   );

   // state register
   always_ff @(posedge clk or posedge clr)
      if (clr) state <= S_IDLE;
      else state <= next;

   // next-state: mem_ready beats timeout; halt beats branch beats run
   always_comb begin
      next = state;
      case (state)
         S_IDLE:   next = run ? S_T0 : S_IDLE;
         S_T0:     next = S_T1;
         S_T1:     next = mem_ready ? S_T2 : expired ? S_FAULT : S_T1;
         S_T2:     next = S_EXEC;
         S_EXEC:   next = !exec_done ? S_EXEC : halt_req ? S_HALTED :
                          branch_req ? S_BRANCH : run ? S_T0 : S_IDLE;
         S_BRANCH: next = run ? S_T0 : S_IDLE;
         default:  next = state;
      endcase
   end

   // Moore strobe decode
   always_comb begin
      s = '0;
      case (state)
         S_T0:     {s.pc_out, s.mar_in, s.inc_pc, s.z_in} = 4'hf;
         S_T1:     {s.z_lo_out, s.pc_in, s.mem_read, s.mdr_in} = 4'hf;
         S_T2:     {s.mdr_out, s.ir_in} = 2'b11;
         S_EXEC:   s.exec_active = 1'b1;
         S_BRANCH: {s.branch_out, s.pc_in} = 2'b11;
         S_HALTED: s.halted = 1'b1;
         S_FAULT:  s.fault = 1'b1;
         default:  s = '0;
      endcase
   end

   // count completed T2 steps
   always_ff @(posedge clk or posedge clr)
      if (clr) instr_count <= '0;
      else if (state == S_T2) instr_count <= instr_count + 32'd1;

   assign {pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, mem_read, mdr_in,
           mdr_out, ir_in, branch_out, exec_active, halted, fault} = s;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch and PC-update sequencer for the 32-bit bus-based CPU. It generates the per-step control strobes for the PC register, MAR, Z, MDR and IR across the fetch steps T0–T2. It waits on memory and the execute-phase control unit, and applies branch and jump PC loads. It sits between the control unit and the datapath registers and is the sole owner of the PC's load/increment controls.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles spent in T1 waiting for `mem_ready` before faulting; legal range 1–255.
- `clk` in 1: rising-edge clock.
- `clr` in 1: asynchronous, active-high reset.
- `run` in 1: level; permits starting a new fetch.
- `mem_ready` in 1: memory read data valid in MDR path this cycle.
- `exec_done` in 1: control unit finished execute phase (1-cycle pulse).
- `branch_req` in 1: qualified with `exec_done`; datapath must drive target onto bus in BRANCH step.
- `halt_req` in 1: qualified with `exec_done`.
- `pc_out`, `mar_in`, `inc_pc`, `z_in` out 1: T0 strobes.
- `z_lo_out`, `pc_in`, `mem_read`, `mdr_in` out 1: T1 strobes (`pc_in` also in BRANCH).
- `mdr_out`, `ir_in` out 1: T2 strobes.
- `branch_out` out 1: tells datapath to drive branch target on bus (BRANCH only).
- `exec_active` out 1: high in EXEC.
- `halted` out 1, `fault` out 1: sticky status.
- `instr_count` out 32: number of completed T2 steps, wraps 0xFFFFFFFF→0.

## Operation
- States: IDLE, T0, T1, T2, EXEC, BRANCH, HALTED, FAULT. All strobes are Moore-decoded from state; no strobe depends combinationally on inputs.
- IDLE: no strobes. Goes to T0 when `run`=1.
- T0: `pc_out`, `mar_in`, `inc_pc`, `z_in`. Unconditionally goes to T1.
- T1: `z_lo_out`, `pc_in`, `mem_read`, `mdr_in`, all held while waiting.
  - `mem_ready`=1 → T2.
  - Otherwise the wait counter increments. When the counter equals `MEM_TIMEOUT` and `mem_ready`=0 → FAULT.
  - The wait counter clears on T1 entry.
- T2: `mdr_out`, `ir_in`. `instr_count` increments by 1. Goes to EXEC.
- EXEC: `exec_active`=1. Stays until `exec_done`=1, then takes the first matching priority:
  - `halt_req` → HALTED;
  - `branch_req` → BRANCH;
  - `run` → T0;
  - else → IDLE.
- BRANCH: `branch_out`, `pc_in` for exactly one cycle. Goes to T0 if `run`, else IDLE.
- HALTED: `halted`=1. FAULT: `fault`=1. Both are terminal; only `clr` exits.
- `run` deasserting mid-fetch does not abort; it is only sampled in IDLE, EXEC exit and BRANCH exit.
- `branch_req`/`halt_req` are ignored unless `exec_done`=1 in EXEC.

## Timing
- Reset (async, immediate): state IDLE, every strobe 0, `exec_active` 0, `halted` 0, `fault` 0, `instr_count` 0, wait counter 0.
- `clr` asserted mid-operation forces the reset values within the same cycle. The first T0 occurs one edge after `clr` falls with `run`=1.
- Minimum instruction with `mem_ready` already high at T1 and `exec_done` on the first EXEC cycle:
  - steps T0, T1, T2, EXEC = 4 cycles;
  - back-to-back fetch has no idle cycle.
- Branch adds exactly 1 cycle.
- Timeout: T1 is occupied at most `MEM_TIMEOUT`+1 cycles. With `MEM_TIMEOUT`=15 and no `mem_ready`, FAULT is entered on the edge after the 16th T1 cycle.
- `mem_ready` on the final permitted T1 cycle wins over timeout.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - the state encoding (3-bit, IDLE=0, T0=1, T1=2, T2=3, EXEC=4, BRANCH=5, HALTED=6, FAULT=7);
  - the strobe bundle type, so the control unit and datapath share one definition.
- One sub-module: `wait_timer`, an 8-bit clearable up-counter with `clr`/`start`/`tick` and `expired` compare against `MEM_TIMEOUT`.
- Strobe decode stays in the top level.

## Test plan
- Reset then `run`=1, `mem_ready`=1, `exec_done` pulsed on the first EXEC cycle:
  - state sequence T0,T1,T2,EXEC repeats every 4 cycles;
  - `instr_count`=3 after 3 instructions;
  - `inc_pc`, `pc_out` high only in T0.
- `mem_ready` delayed 5 cycles: T1 held 6 cycles with `mem_read`/`pc_in` steady; T2 follows the edge after `mem_ready`.
- `mem_ready` never asserted, `MEM_TIMEOUT`=15: `fault`=1 after 16 T1 cycles; stays set through further `run`/`exec_done`; cleared only by `clr`.
- `exec_done` with `branch_req`=1 and `halt_req`=1 together: HALTED entered, no BRANCH cycle. With `branch_req` alone: one BRANCH cycle with `branch_out`=`pc_in`=1, then T0.
- `clr` pulsed asynchronously mid-T1 (between edges): all outputs 0 immediately and `instr_count`=0. With `run`=0 afterwards, the block stays in IDLE.
